// File: rtl/mulalu_pkg.sv
// mulalu_pkg: shared types and constants for the EX-stage multiply/divide unit.
//   W_FUNC / W_DATA   : request-code and datapath widths
//   FUNC_MUL/FUNC_DIV : request codes on mulalu_func (0 = no request)
//   mulalu_state_t    : unit FSM state
//   mag()             : operand magnitude, only applied when signed
package mulalu_pkg;

    localparam int W_FUNC = 5;
    localparam int W_DATA = 32;

    localparam logic [W_FUNC-1:0] FUNC_MUL = 5'd1;
    localparam logic [W_FUNC-1:0] FUNC_DIV = 5'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } mulalu_state_t;

    // 0x8000_0000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [W_DATA-1:0] mag(input logic [W_DATA-1:0] v,
                                              input logic              is_signed);
        return (is_signed && v[W_DATA-1]) ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/mulalu_divcore.sv
// divcore: one radix-2 restoring-division step.
//   rem_in/rem_out  : 33-bit partial remainder
//   quo_in/quo_out  : dividend bits shifting out / quotient bits shifting in
//   divisor         : divisor magnitude
module divcore
    import mulalu_pkg::*;
(
    input  logic [W_DATA:0]   rem_in,
    input  logic [W_DATA-1:0] quo_in,
    input  logic [W_DATA-1:0] divisor,
    output logic [W_DATA:0]   rem_out,
    output logic [W_DATA-1:0] quo_out
);

    // One extra bit above the remainder so the trial subtraction carries its
    // own sign without losing the shifted-out remainder MSB.
    logic [W_DATA+1:0] rem_sh;
    logic [W_DATA+1:0] trial;

    always_comb begin
        rem_sh  = {rem_in, quo_in[W_DATA-1]};
        trial   = rem_sh - {2'b00, divisor};
        rem_out = rem_sh[W_DATA:0];
        quo_out = {quo_in[W_DATA-2:0], 1'b0};
        if (!trial[W_DATA+1]) begin
            rem_out    = trial[W_DATA:0];
            quo_out[0] = 1'b1;
        end
    end

endmodule

// File: rtl/mulalu.sv
// mulalu: multi-cycle multiply/divide unit for the EX stage.
//   clk, rst_n          : clock, asynchronous active-low reset
//   mulalu_func         : FUNC_MUL, FUNC_DIV or 0 (no request)
//   mulalu_sign         : 1 = signed (MULT/DIV), 0 = unsigned
//   source_a, source_b  : multiplicand/dividend, multiplier/divisor
//   flush               : abort current operation, suppress write pulses
//   stall               : hold EX and upstream while the unit is busy
//   hi_write/lo_write   : one-cycle write strobes in DONE
//   hi_write_data/lo_write_data : registered results, held between strobes
// Multiply takes 2 cycles (accept, MUL), divide 33 (accept + 32 steps);
// the write pulse comes in the following DONE cycle.
module mulalu
    import mulalu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [W_FUNC-1:0] mulalu_func,
    input  logic              mulalu_sign,
    input  logic [W_DATA-1:0] source_a,
    input  logic [W_DATA-1:0] source_b,
    input  logic              flush,
    output logic              stall,
    output logic              hi_write,
    output logic [W_DATA-1:0] hi_write_data,
    output logic              lo_write,
    output logic [W_DATA-1:0] lo_write_data
);

    mulalu_state_t     state, state_nx;
    logic [4:0]        cnt;
    logic [W_DATA-1:0] op_a;      // multiplicand, or dividend/quotient during DIV
    logic [W_DATA-1:0] op_b;      // multiplier, or divisor magnitude during DIV
    logic              sign_r;
    logic [W_DATA:0]   rem;
    logic              q_neg, r_neg;
    logic [W_DATA-1:0] hi_res, lo_res;

    logic              req, accept;
    logic [W_DATA:0]   rem_nx;
    logic [W_DATA-1:0] quo_nx, quo_fix, rem_fix;
    logic signed [W_DATA:0]     ext_a, ext_b;
    logic signed [2*W_DATA-1:0] prod;

    assign req    = (mulalu_func != '0);
    assign accept = (state == IDLE) && req && !flush;

    divcore u_divcore (
        .rem_in  (rem),
        .quo_in  (op_a),
        .divisor (op_b),
        .rem_out (rem_nx),
        .quo_out (quo_nx)
    );

    always_comb begin
        ext_a   = {sign_r & op_a[W_DATA-1], op_a};
        ext_b   = {sign_r & op_b[W_DATA-1], op_b};
        prod    = 64'(ext_a) * 64'(ext_b);
        quo_fix = q_neg ? (~quo_nx + 1'b1) : quo_nx;
        rem_fix = r_neg ? (~rem_nx[W_DATA-1:0] + 1'b1) : rem_nx[W_DATA-1:0];
    end

    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (req) state_nx = (mulalu_func == FUNC_DIV) ? DIV : MUL;
                MUL:     state_nx = DONE;
                DIV:     if (cnt == 5'd31) state_nx = DONE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            op_a   <= '0;
            op_b   <= '0;
            sign_r <= 1'b0;
            rem    <= '0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            hi_res <= '0;
            lo_res <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                sign_r <= mulalu_sign;
                cnt    <= '0;
                rem    <= '0;
                if (mulalu_func == FUNC_DIV) begin
                    op_a  <= mag(source_a, mulalu_sign);
                    op_b  <= mag(source_b, mulalu_sign);
                    // Divide by zero skips the quotient negation so LO stays
                    // all ones; the remainder negation restores the raw
                    // dividend into HI.
                    q_neg <= mulalu_sign & (source_a[W_DATA-1] ^ source_b[W_DATA-1])
                             & (source_b != '0);
                    r_neg <= mulalu_sign & source_a[W_DATA-1];
                end else begin
                    op_a <= source_a;
                    op_b <= source_b;
                end
            end else if (!flush && state == MUL) begin
                hi_res <= prod[2*W_DATA-1:W_DATA];
                lo_res <= prod[W_DATA-1:0];
            end else if (!flush && state == DIV) begin
                rem  <= rem_nx;
                op_a <= quo_nx;
                cnt  <= cnt + 5'd1;
                if (cnt == 5'd31) begin
                    hi_res <= rem_fix;
                    lo_res <= quo_fix;
                end
            end
        end
    end

    always_comb begin
        stall         = accept || (state == MUL) || (state == DIV);
        hi_write      = (state == DONE) && !flush;
        lo_write      = (state == DONE) && !flush;
        hi_write_data = hi_res;
        lo_write_data = lo_res;
    end

endmodule

// File: tb/tb_mulalu.sv
// tb_mulalu: directed self-checking bench for mulalu.
module tb_mulalu;
    import mulalu_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [W_FUNC-1:0] mulalu_func;
    logic              mulalu_sign;
    logic [W_DATA-1:0] source_a, source_b;
    logic              flush;
    logic              stall, hi_write, lo_write;
    logic [W_DATA-1:0] hi_write_data, lo_write_data;

    int checks = 0;
    int errors = 0;

    mulalu dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mulalu_func   (mulalu_func),
        .mulalu_sign   (mulalu_sign),
        .source_a      (source_a),
        .source_b      (source_b),
        .flush         (flush),
        .stall         (stall),
        .hi_write      (hi_write),
        .hi_write_data (hi_write_data),
        .lo_write      (lo_write),
        .lo_write_data (lo_write_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one request in the next cycle and follows it to DONE.
    task automatic run_op(input string tag, input logic [W_FUNC-1:0] f, input logic s,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input int estall);
        int n;
        int early;
        @(posedge clk); #1;
        mulalu_func = f; mulalu_sign = s; source_a = a; source_b = b;
        #1;
        n = 0; early = 0;
        while (stall && n < 100) begin
            n++;
            if (hi_write || lo_write) early++;
            @(posedge clk); #1;
            mulalu_func = '0;
            #1;
        end
        mulalu_func = '0;
        chk({tag, " stall_cycles"}, n, estall);
        chk({tag, " early_write"}, early, 0);
        chk({tag, " hi_write"}, hi_write, 1);
        chk({tag, " lo_write"}, lo_write, 1);
        chk({tag, " hi"}, hi_write_data, ehi);
        chk({tag, " lo"}, lo_write_data, elo);
    endtask

    // Starts a divide, aborts it at T+10 by flush or reset, checks no write follows.
    task automatic abort_div(input string tag, input logic use_rst);
        int w;
        @(posedge clk); #1;
        mulalu_func = FUNC_DIV; mulalu_sign = 1'b0; source_a = 32'd1000; source_b = 32'd3;
        #1;
        chk({tag, " stall_at_T"}, stall, 1);
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            mulalu_func = '0;
            #1;
        end
        if (use_rst) begin
            rst_n = 1'b0; #1;
            chk({tag, " stall_in_reset"}, stall, 0);
            chk({tag, " hi_data_reset"}, hi_write_data, 0);
            chk({tag, " lo_data_reset"}, lo_write_data, 0);
            rst_n = 1'b1;
        end else begin
            flush = 1'b1; #1;
            chk({tag, " hi_write_flush"}, hi_write, 0);
        end
        @(posedge clk); #1;
        flush = 1'b0;
        #1;
        chk({tag, " stall_T11"}, stall, 0);
        chk({tag, " state_idle"}, dut.state, IDLE);
        w = 0;
        for (int i = 0; i < 40; i++) begin
            if (hi_write || lo_write) w++;
            @(posedge clk); #2;
        end
        chk({tag, " no_write"}, w, 0);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; mulalu_func = '0; mulalu_sign = 1'b0;
        source_a = '0; source_b = '0;
        #12;
        chk("reset stall", stall, 0);
        chk("reset hi_write", hi_write, 0);
        chk("reset lo_write", lo_write, 0);
        chk("reset hi_data", hi_write_data, 0);
        chk("reset lo_data", lo_write_data, 0);
        chk("reset state", dut.state, IDLE);
        rst_n = 1'b1;

        run_op("mult_neg1x2",  FUNC_MUL, 1'b1, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
        run_op("multu_ffx2",   FUNC_MUL, 1'b0, 32'hFFFF_FFFF, 32'h2, 32'h0000_0001, 32'hFFFF_FFFE, 2);
        run_op("multu_ffxff",  FUNC_MUL, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 2);
        run_op("mult_minxmin", FUNC_MUL, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 2);
        run_op("div_m7_2",     FUNC_DIV, 1'b1, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
        run_op("divu_7_0",     FUNC_DIV, 1'b0, 32'h7, 32'h0, 32'h0000_0007, 32'hFFFF_FFFF, 33);
        run_op("div_m5_0",     FUNC_DIV, 1'b1, 32'hFFFF_FFFB, 32'h0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 33);
        run_op("div_min_m1",   FUNC_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33);
        run_op("divu_100_7",   FUNC_DIV, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 33);
        run_op("div_7_m2",     FUNC_DIV, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 33);
        run_op("divu_ff_1",    FUNC_DIV, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 33);

        // Cycle after DONE: strobes drop, data holds.
        @(posedge clk); #2;
        chk("hold hi_write", hi_write, 0);
        chk("hold hi_data", hi_write_data, 32'd0);
        chk("hold lo_data", lo_write_data, 32'hFFFF_FFFF);

        // Back-to-back: DIV request on the cycle right after the MUL's DONE.
        run_op("b2b_mul", FUNC_MUL, 1'b1, 32'd3, 32'd5, 32'd0, 32'd15, 2);
        run_op("b2b_div", FUNC_DIV, 1'b0, 32'd20, 32'd6, 32'd2, 32'd3, 33);

        abort_div("flush_div", 1'b0);
        abort_div("reset_div", 1'b1);

        // Flush arriving in DONE suppresses the write pulse.
        @(posedge clk); #1;
        mulalu_func = FUNC_MUL; mulalu_sign = 1'b0; source_a = 32'd9; source_b = 32'd9;
        @(posedge clk); #1;
        mulalu_func = '0;
        @(posedge clk); #1;
        flush = 1'b1; #1;
        chk("done_flush state", dut.state, DONE);
        chk("done_flush hi_write", hi_write, 0);
        chk("done_flush lo_write", lo_write, 0);
        @(posedge clk); #1;
        flush = 1'b0; #1;
        chk("done_flush idle", dut.state, IDLE);
        chk("done_flush no_write", hi_write, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mulalu.md
# mulalu

Multi-cycle multiply/divide unit in the EX stage. Consumes the `mulalu_func` / `mulalu_sign` request and the operands `source_a` / `source_b` produced by the single-cycle EX ALU. Produces 64-bit HI/LO results:
- 2-cycle signed/unsigned multiply.
- 33-cycle radix-2 restoring divide.

It stalls the pipeline while busy and emits one-cycle HI/LO write pulses that the EX stage merges with MTHI/MTLO writes.

## Interface
No parameters. Widths come from `defines.vh`: `W_FUNC` = 5 bits, `W_DATA` = 32 bits.
- `clk` in 1 — the only clock.
- `rst_n` in 1 — asynchronous, active-low reset.
- `mulalu_func` in W_FUNC — `FUNC_MUL`, `FUNC_DIV`, or 0 (no request).
- `mulalu_sign` in 1 — 1 = signed (MULT/DIV), 0 = unsigned (MULTU/DIVU).
- `source_a` in W_DATA — multiplicand / dividend.
- `source_b` in W_DATA — multiplier / divisor.
- `flush` in 1 — abort the current operation (exception or pipeline flush).
- `stall` out 1 — hold the EX stage and everything upstream.
- `hi_write` out 1 — one-cycle HI write pulse.
- `hi_write_data` out W_DATA — value to write to HI.
- `lo_write` out 1 — one-cycle LO write pulse.
- `lo_write_data` out W_DATA — value to write to LO.

## Operation
- Request: `req` = (`mulalu_func` != 0). Accepted only in IDLE with `flush`=0.
- States are IDLE, MUL, DIV, DONE.
- IDLE with req:
  - MUL: latch operands and sign; go to MUL.
  - DIV: latch |a| and |b| (magnitudes only when signed), the quotient sign (a[31]^b[31]) and the remainder sign (a[31]); clear the 5-bit counter and the 33-bit partial remainder; go to DIV.
- MUL: compute the 64-bit product (sign-extend or zero-extend operands to 33 bits); register HI = p[63:32], LO = p[31:0]; go to DONE.
- DIV: each cycle:
  - shift {rem, quo} left by 1.
  - trial = rem - divisor.
  - If trial is non-negative: rem = trial, quo[0] = 1.
  - After the 32nd step (counter == 31): apply sign fix-up and go to DONE.
    - Negate quo if the quotient sign is 1.
    - Negate rem if the remainder sign is 1.
- DONE: `hi_write` = `lo_write` = 1 with the registered results; next state IDLE. A new request is not accepted in DONE.
- Divide by zero (b == 0): the result falls out of the algorithm with no fix-up. LO = 32'hFFFF_FFFF, HI = `source_a` (raw operand).
- Signed 0x8000_0000 / 0xFFFF_FFFF: LO = 0x8000_0000, HI = 0. No trap.
- `flush` in any state: next state IDLE; write pulses are suppressed in that cycle (flush wins over DONE).
- `stall` = (state==IDLE & req & ~flush) | state==MUL | state==DIV. `stall` is 0 in DONE, so the instruction retires on that cycle.

## Timing
- Reset (asynchronous, `rst_n`=0): state IDLE; counter, operands and results cleared; `stall`=0, `hi_write`=`lo_write`=0, `hi_write_data`=`lo_write_data`=0. Reset mid-operation discards the operation with no write.
- MUL accepted at cycle T:
  - `stall` high at T and T+1.
  - DONE at T+2: write pulse, `stall`=0.
- DIV accepted at cycle T:
  - `stall` high T..T+32.
  - Iterations run T+1..T+32.
  - DONE at T+33.
- Back-to-back: a request present on the cycle after DONE is accepted normally. There is no idle bubble beyond the DONE cycle.
- Data outputs hold their last value outside DONE; only the write strobes are pulsed.

## Structure
- `FUNC_MUL`, `FUNC_DIV`, `W_FUNC` and `W_DATA` stay in `defines.vh`.
- The state enum (IDLE/MUL/DIV/DONE) goes in the shared package as `mulalu_state_t`.
- One sub-module, `divcore`: a single restoring-division step (rem, quo, divisor in → rem, quo out). The FSM, counter and sign fix-up stay in `mulalu`.

## Test plan
- Signed MUL 0xFFFF_FFFF × 0x0000_0002 → at T+2: HI = 0xFFFF_FFFF, LO = 0xFFFF_FFFE; `stall` high exactly 2 cycles.
- Unsigned MUL with the same operands → HI = 0x0000_0001, LO = 0xFFFF_FFFE.
- Signed DIV −7 (0xFFFF_FFF9) / 2 → at T+33: LO = 0xFFFF_FFFD, HI = 0xFFFF_FFFF; `stall` high 33 cycles.
- Unsigned DIV 7 / 0 → LO = 0xFFFF_FFFF, HI = 0x0000_0007.
- DIV accepted, `flush` at T+10 → no write pulse ever, `stall`=0 from T+11, state IDLE. Repeat with `rst_n` pulsed low at T+10 → same outcome.
- MUL then DIV back-to-back → two write pulses, at T+2 and T+36; the second request is accepted at T+3.
